bcd_press_counter_mux: RTL
==========================

BCD_PRESS_COUNTER_MUX -- requirements
Module: bcd_press_counter_mux

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits and anodes (legal 1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 3, consecutive stable cycles needed to accept a button level change (legal 1..1023).
REQ-003 SHALL have parameter REFRESH_DIV, default 4, clock cycles each digit stays selected (legal 1..65535).
REQ-004 SHALL have port i_w_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_w_reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_w_button  input  1  raw, asynchronous push-button level.
REQ-007 SHALL have port i_w_up_down  input  1  count mode: 1 = up, 0 = down.
REQ-008 SHALL have port o_r_an  output  DIGITS  anode selects, active-low, one-hot-low; bit k selects digit k (k=0 is least significant).
REQ-009 SHALL have port o_r_seg  output  7  segments {CG,CF,CE,CD,CC,CB,CA}, active-low.
REQ-010 SHALL have port o_r_dp  output  1  decimal point, active-low.
REQ-011 SHALL have port o_r_overflow  output  1  one-cycle pulse on count wrap.

Function
REQ-012 SHALL synchronise i_w_button through two flops before any other use.
REQ-013 SHALL change the debounced level only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any shorter disagreement restarts the run.
REQ-014 SHALL generate one press event per 0->1 transition of the debounced level; a held button yields exactly one event.
REQ-015 SHALL update the count on the clock edge after the press event is registered: 3+DEBOUNCE_CYCLES rising edges after the first edge that samples i_w_button high, with the button held high throughout.
REQ-016 SHALL sample i_w_up_down on the count-update edge only; mode changes between presses affect no state.
REQ-017 SHALL hold the count as DIGITS BCD nibbles, each 0..9; up adds 1 with decimal carry, down subtracts 1 with decimal borrow.
REQ-018 SHALL wrap up from all-9s to 0 and down from 0 to all-9s; on either wrap it SHALL assert o_r_overflow for exactly the cycle after the update edge.
REQ-019 SHALL scan digit index 0,1,...,DIGITS-1,0,... advancing every REFRESH_DIV cycles; with DIGITS=1 o_r_an SHALL be constantly 0.
REQ-020 SHALL drive o_r_seg with the standard active-low decode of the selected digit (0 = 7'b1000000, 1 = 7'b1111001, ..., 9 = 7'b0010000).
REQ-021 SHALL blank (o_r_seg = 7'h7F) a selected digit k>0 whose nibble and all higher nibbles are 0; digit 0 is never blanked.
REQ-022 SHALL drive o_r_dp = 0 only while digit 0 is selected and the last sampled mode is down; otherwise o_r_dp = 1.
REQ-023 SHALL register all outputs; anode, segment and dp changes SHALL occur on the same edge with no mixed-digit cycle.

Reset
REQ-024 SHALL, while i_w_reset = 0, force count = 0, sampled mode = up, debounced level = 0, debounce and refresh counters = 0, digit index = 0.
REQ-025 SHALL drive during reset o_r_an = all-ones except bit 0 = 0, o_r_seg = 7'b1000000, o_r_dp = 1, o_r_overflow = 0.
REQ-026 SHALL discard any press in progress when reset asserts mid-debounce; a button held across reset release SHALL produce one event after DEBOUNCE_CYCLES.

Structure
REQ-027 SHALL place the 7-segment decode constants, blank pattern and parameter defaults in shared package seg7_pkg.
REQ-028 SHALL implement REQ-012..REQ-014 in sub-module button_debouncer (parameter DEBOUNCE_CYCLES, output one-cycle press pulse).

Verification
REQ-029 Defaults, 2 ns clock, reset then 14 pulses of 10 ns high / 10 ns low, up -> count 0014; digits 2,3 blanked; no overflow.
REQ-030 Defaults, 1-cycle and 2-cycle high glitches -> count unchanged; 3+-cycle hold -> exactly +1, 6 edges after first high sample.
REQ-031 DIGITS=2, count 99, up press -> count 00, o_r_overflow high one cycle; down press from 00 -> 99, overflow one cycle.
REQ-032 Defaults, count 0100, down press -> 0099 (borrow across two digits); o_r_dp = 0 while digit 0 is selected.
REQ-033 Hold button 200 cycles -> one increment; toggle i_w_up_down while held -> no count change.
REQ-034 Assert reset mid-debounce and mid-scan -> outputs immediately equal REQ-025 values; scan restarts at digit 0 with REFRESH_DIV spacing.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the BCD press counter: parameter defaults,
// 7-segment patterns and BCD digit arithmetic.
package seg7_pkg;

  localparam int DIGITS_DEF   = 4;
  localparam int DEBOUNCE_DEF = 3;
  localparam int REFRESH_DEF  = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic {
    MODE_DOWN = 1'b0,
    MODE_UP   = 1'b1
  } mode_e;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Returns {carry_or_borrow, next_nibble}
  function automatic logic [4:0] bcd_step(
    input logic [3:0] n,
    input logic       up
  );
    logic [4:0] r;
    if (up) begin
      r = (n >= 4'd9) ? 5'b1_0000 : {1'b0, n + 4'd1};
    end else begin
      r = (n == 4'd0) ? 5'b1_1001 : {1'b0, n - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, run-length debouncer and
// single-cycle rising-edge press pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic       sync1;
  logic       sync2;
  logic       level;
  logic [9:0] run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      run   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (run == 10'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          run   <= '0;
          press <= sync2;
        end else begin
          run <= run + 10'd1;
        end
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/bcd_press_counter_mux.sv
// Debounced press counter in BCD with a multiplexed
// active-low 7-segment display and wrap pulse.
module bcd_press_counter_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS          = DIGITS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REFRESH_DIV     = REFRESH_DEF
) (
  input  logic              i_w_clk,
  input  logic              i_w_reset,
  input  logic              i_w_button,
  input  logic              i_w_up_down,
  output logic [DIGITS-1:0] o_r_an,
  output logic [6:0]        o_r_seg,
  output logic              o_r_dp,
  output logic              o_r_overflow
);

  localparam int CW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              press;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  mode_e             mode_q;
  mode_e             mode_d;
  logic              carry;
  logic              wrap;
  logic [15:0]       ref_q;
  logic [15:0]       ref_d;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     idx_d;
  logic [3:0]        nib;
  logic              hi_zero;
  logic [DIGITS-1:0] an_d;
  logic [6:0]        seg_d;
  logic              dp_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (i_w_clk),
    .rst_n(i_w_reset),
    .btn  (i_w_button),
    .press(press)
  );

  always_comb begin
    count_d = count_q;
    mode_d  = mode_q;
    carry   = 1'b0;
    wrap    = 1'b0;
    if (press) begin
      mode_d = i_w_up_down ? MODE_UP : MODE_DOWN;
      carry  = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (carry) begin
          {carry, count_d[4*k +: 4]} =
            bcd_step(count_q[4*k +: 4], i_w_up_down);
        end
      end
      wrap = carry;
    end
  end

  always_comb begin
    ref_d = ref_q + 16'd1;
    idx_d = idx_q;
    if (ref_q == 16'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Outputs are built from next-state values so every
  // registered output flips on the same edge as the state.
  always_comb begin
    nib     = '0;
    hi_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nib = count_d[4*k +: 4];
      end
      if (k >= int'(idx_d) && count_d[4*k +: 4] != 4'd0) begin
        hi_zero = 1'b0;
      end
    end
    an_d  = ~(DIGITS'(1) << idx_d);
    seg_d = (idx_d != '0 && hi_zero) ? SEG_BLANK : seg7_decode(nib);
    dp_d  = !(idx_d == '0 && mode_d == MODE_DOWN);
  end

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      count_q      <= '0;
      mode_q       <= MODE_UP;
      ref_q        <= '0;
      idx_q        <= '0;
      o_r_an       <= ~DIGITS'(1);
      o_r_seg      <= SEG_ZERO;
      o_r_dp       <= 1'b1;
      o_r_overflow <= 1'b0;
    end else begin
      count_q      <= count_d;
      mode_q       <= mode_d;
      ref_q        <= ref_d;
      idx_q        <= idx_d;
      o_r_an       <= an_d;
      o_r_seg      <= seg_d;
      o_r_dp       <= dp_d;
      o_r_overflow <= wrap;
    end
  end

endmodule
